wb_stage: RTL and testbench

Write-back stage of the pipelined ARM-subset core: the writer side of the register-file write port. Accepts retiring instructions from the MEM stage, selects the ALU result or the load data, and drives the registered write port `writeBackEn` / `dest_wb` / `Result_WB` that the register file samples on the falling clock edge. It also handles multi-cycle load data via a valid handshake with a timeout, and keeps a retired-instruction counter.

---
 rtl/wb_stage.sv | 150 +++++++++++++++
 tb/tb_wb_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - write-back stage: result select, load-wait handshake, retire count
// Define WB_FWD_EN to add the fwd_valid/fwd_dest/fwd_data forwarding taps.
module wb_stage #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 16,
  parameter int RET_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              mem_wb_en,
  input  logic              mem_r_en,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdata_valid,
  output logic              ready_out,
`ifdef WB_FWD_EN
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_dest,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic              writeBackEn,
  output logic [ADDR_W-1:0] dest_wb,
  output logic [DATA_W-1:0] Result_WB,
  output logic              err,
  output logic [RET_W-1:0]  retired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] PC_IDX = '1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            r_state, w_state_nx;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
  logic [ADDR_W-1:0] r_dest_lat, w_dest_lat_nx;
  logic              r_wb_en, w_wb_en_nx;
  logic [ADDR_W-1:0] r_dest, w_dest_nx;
  logic [DATA_W-1:0] r_result, w_result_nx;
  logic              r_err, w_err_nx;
  logic [RET_W-1:0]  r_retired, w_retired_nx;

  logic              w_retire;
  logic              w_do_wr;
  logic [ADDR_W-1:0] w_wr_dest;
  logic [DATA_W-1:0] w_wr_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_dest_lat <= '0;
      r_wb_en    <= 1'b0;
      r_dest     <= '0;
      r_result   <= '0;
      r_err      <= 1'b0;
      r_retired  <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_dest_lat <= w_dest_lat_nx;
      r_wb_en    <= w_wb_en_nx;
      r_dest     <= w_dest_nx;
      r_result   <= w_result_nx;
      r_err      <= w_err_nx;
      r_retired  <= w_retired_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_dest_lat_nx = r_dest_lat;
    w_wb_en_nx    = 1'b0;
    w_dest_nx     = r_dest;
    w_result_nx   = r_result;
    w_err_nx      = r_err;
    w_retired_nx  = r_retired;
    w_retire      = 1'b0;
    w_do_wr       = 1'b0;
    w_wr_dest     = mem_dest;
    w_wr_data     = mem_alu_result;

    case (r_state)
      S_IDLE: begin
        if (!flush && !freeze && mem_valid) begin
          if (!mem_wb_en) begin
            w_retire = 1'b1;
          end else if (!mem_r_en) begin
            w_do_wr = 1'b1;
          end else if (mem_rdata_valid) begin
            w_do_wr   = 1'b1;
            w_wr_data = mem_rdata;
          end else begin
            w_dest_lat_nx = mem_dest;
            w_cnt_nx      = '0;
            w_state_nx    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // Data arriving on the final wait cycle still beats the timeout.
        if (flush) begin
          w_state_nx = S_IDLE;
        end else if (mem_rdata_valid) begin
          w_do_wr    = 1'b1;
          w_wr_dest  = r_dest_lat;
          w_wr_data  = mem_rdata;
          w_state_nx = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_err_nx   = 1'b1;
          w_state_nx = S_IDLE;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase

    // The PC is outside the register file: it retires but never strobes a write.
    if (w_do_wr) begin
      w_retire    = 1'b1;
      w_dest_nx   = w_wr_dest;
      w_result_nx = w_wr_data;
      w_wb_en_nx  = (w_wr_dest != PC_IDX);
    end
    if (w_retire) begin
      w_retired_nx = r_retired + 1'b1;
    end
  end

  assign ready_out   = (r_state == S_IDLE);
  assign writeBackEn = r_wb_en;
  assign dest_wb     = r_dest;
  assign Result_WB   = r_result;
  assign err         = r_err;
  assign retired     = r_retired;

`ifdef WB_FWD_EN
  assign fwd_valid = r_wb_en && (r_dest != PC_IDX);
  assign fwd_dest  = r_dest;
  assign fwd_data  = r_result;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed scoreboard bench for wb_stage
// Define WB_FWD_EN to also check the forwarding taps.
module tb_wb_stage;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 16;
  localparam int RET_W   = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              freeze, flush, mem_valid, mem_wb_en, mem_r_en, mem_rdata_valid;
  logic [ADDR_W-1:0] mem_dest;
  logic [DATA_W-1:0] mem_alu_result, mem_rdata;
  logic              ready_out, writeBackEn, err;
  logic [ADDR_W-1:0] dest_wb;
  logic [DATA_W-1:0] Result_WB;
  logic [RET_W-1:0]  retired;
`ifdef WB_FWD_EN
  logic              fwd_valid;
  logic [ADDR_W-1:0] fwd_dest;
  logic [DATA_W-1:0] fwd_data;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0] d;
    logic [DATA_W-1:0] v;
  } wr_t;

  wr_t               sb_q[$];
  int                checks = 0;
  int                errors = 0;
  logic [RET_W-1:0]  exp_ret;
  int                n_wrap;

  wb_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .RET_W(RET_W)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .mem_valid(mem_valid), .mem_wb_en(mem_wb_en), .mem_r_en(mem_r_en),
    .mem_dest(mem_dest), .mem_alu_result(mem_alu_result), .mem_rdata(mem_rdata),
    .mem_rdata_valid(mem_rdata_valid), .ready_out(ready_out),
`ifdef WB_FWD_EN
    .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
`endif
    .writeBackEn(writeBackEn), .dest_wb(dest_wb), .Result_WB(Result_WB),
    .err(err), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    mem_valid = 0; mem_wb_en = 0; mem_r_en = 0; mem_rdata_valid = 0;
    mem_dest = '0; mem_alu_result = '0; mem_rdata = '0;
  endtask

  task automatic drive(input logic wb, input logic rd, input logic dv,
                       input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] alu,
                       input logic [DATA_W-1:0] rdat);
    mem_valid = 1; mem_wb_en = wb; mem_r_en = rd; mem_rdata_valid = dv;
    mem_dest = d; mem_alu_result = alu; mem_rdata = rdat;
  endtask

  // One clock, then compare the write port against the scoreboard head.
  task automatic step();
    wr_t e;
    @(posedge clk);
    #1;
    chk("wb_en", writeBackEn, (sb_q.size() > 0));
`ifdef WB_FWD_EN
    chk("fwd_valid", fwd_valid, (sb_q.size() > 0));
`endif
    if (writeBackEn && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("dest_wb", dest_wb, e.d);
      chk("Result_WB", Result_WB, e.v);
`ifdef WB_FWD_EN
      chk("fwd_dest", fwd_dest, e.d);
      chk("fwd_data", fwd_data, e.v);
`endif
    end
  endtask

  initial begin
    rst = 1; freeze = 0; flush = 0; exp_ret = '0;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_en", writeBackEn, 0);
    chk("rst_dest", dest_wb, 0);
    chk("rst_result", Result_WB, 0);
    chk("rst_err", err, 0);
    chk("rst_retired", retired, 0);
    chk("rst_ready", ready_out, 1);
    rst = 0;

    // ALU op
    drive(1, 0, 0, 4'd3, 32'h1234, 32'h0);
    sb_q.push_back('{d: 4'd3, v: 32'h1234}); exp_ret++;
    step();
    idle_in();
    step();
    chk("alu_retired", retired, exp_ret);

    // Load, data valid three cycles after entering WAIT; dest latched
    drive(1, 1, 0, 4'd5, 32'h0, 32'h0);
    step();
    chk("ld_ready0", ready_out, 0);
    mem_dest = 4'd9;
    step();
    chk("ld_ready1", ready_out, 0);
    step();
    chk("ld_ready2", ready_out, 0);
    mem_rdata_valid = 1; mem_rdata = 32'hCAFE;
    sb_q.push_back('{d: 4'd5, v: 32'hCAFE}); exp_ret++;
    step();
    chk("ld_ready_back", ready_out, 1);
    idle_in();
    step();
    chk("ld_retired", retired, exp_ret);

    // Data valid on the last wait cycle beats the timeout
    drive(1, 1, 0, 4'd8, 32'h0, 32'h0);
    step();
    idle_in();
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    chk("coin_ready_low", ready_out, 0);
    mem_rdata_valid = 1; mem_rdata = 32'hBEEF;
    sb_q.push_back('{d: 4'd8, v: 32'hBEEF}); exp_ret++;
    step();
    idle_in();
    chk("coin_err", err, 0);
    chk("coin_ready", ready_out, 1);

    // Timeout with no data
    drive(1, 1, 0, 4'd6, 32'h0, 32'h0);
    step();
    idle_in();
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    chk("to_err_early", err, 0);
    chk("to_ready_low", ready_out, 0);
    step();
    chk("to_err", err, 1);
    chk("to_ready", ready_out, 1);
    chk("to_retired", retired, exp_ret);

    // Freeze holds the port, release lets the op through
    freeze = 1;
    drive(1, 0, 0, 4'd2, 32'h55, 32'h0);
    step();
    chk("frz_dest_hold", dest_wb, 4'd8);
    chk("frz_data_hold", Result_WB, 32'hBEEF);
    step();
    chk("frz_retired", retired, exp_ret);
    freeze = 0;
    sb_q.push_back('{d: 4'd2, v: 32'h55}); exp_ret++;
    step();
    idle_in();
    step();

    // Flush in IDLE squashes the op
    flush = 1;
    drive(1, 0, 0, 4'd3, 32'h77, 32'h0);
    step();
    flush = 0;
    idle_in();
    chk("flush_idle_retired", retired, exp_ret);

    // Flush in WAIT returns to IDLE without writing
    drive(1, 1, 0, 4'd4, 32'h0, 32'h0);
    step();
    idle_in();
    step();
    chk("flw_ready_low", ready_out, 0);
    flush = 1;
    step();
    flush = 0;
    chk("flw_ready", ready_out, 1);
    step();
    chk("flw_retired", retired, exp_ret);

    // PC destination: retires, never writes
    drive(1, 0, 0, 4'hF, 32'h99, 32'h0); exp_ret++;
    step();
    drive(1, 1, 1, 4'hF, 32'h0, 32'h1111); exp_ret++;
    step();
    idle_in();
    step();
    chk("pc_retired", retired, exp_ret);

    // Retire counter wrap
    n_wrap = int'(16'hFFFF - exp_ret);
    drive(0, 0, 0, 4'd0, 32'h0, 32'h0);
    for (int i = 0; i < n_wrap; i++) step();
    exp_ret = 16'hFFFF;
    idle_in();
    step();
    chk("wrap_max", retired, exp_ret);
    drive(0, 0, 0, 4'd0, 32'h0, 32'h0); exp_ret++;
    step();
    idle_in();
    chk("wrap_zero", retired, exp_ret);

    // Asynchronous reset mid-WAIT
    drive(1, 0, 0, 4'd1, 32'hA5A5, 32'h0);
    sb_q.push_back('{d: 4'd1, v: 32'hA5A5}); exp_ret++;
    step();
    drive(1, 1, 0, 4'd2, 32'h0, 32'h0);
    step();
    idle_in();
    chk("mw_ready_low", ready_out, 0);
    #2;
    rst = 1;
    #1;
    chk("mw_rst_ready", ready_out, 1);
    chk("mw_rst_wb_en", writeBackEn, 0);
    chk("mw_rst_dest", dest_wb, 0);
    chk("mw_rst_result", Result_WB, 0);
    chk("mw_rst_err", err, 0);
    chk("mw_rst_retired", retired, 0);
`ifdef WB_FWD_EN
    chk("mw_rst_fwd_valid", fwd_valid, 0);
    chk("mw_rst_fwd_data", fwd_data, 0);
`endif
    rst = 0;
    mem_rdata_valid = 1; mem_rdata = 32'hDEAD;
    step();
    mem_rdata_valid = 0;
    chk("post_rst_retired", retired, 0);
    chk("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
